// File: rtl/ins_fetch_pkg.sv
// rtl/ins_fetch_pkg.sv - shared opcodes, FSM states and word decode for the note fetcher
package ins_fetch_pkg;

    localparam logic [3:0] OP_END   = 4'b0000;
    localparam logic [3:0] OP_BPM   = 4'b0001;
    localparam int         NOTE_BIT = 15;
    localparam int         ENTRY_W  = 28;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_WAIT,
        ST_CAPTURE,
        ST_HALT
    } state_e;

    typedef enum logic [1:0] {
        W_NOTE,
        W_BPM,
        W_END,
        W_ILLEGAL
    } word_e;

    // A BPM word carrying tempo 0 is treated as illegal rather than loaded.
    function automatic word_e decode_word(input logic [15:0] w);
        word_e k;
        if (w[NOTE_BIT])
            k = W_NOTE;
        else if (w[15:12] == OP_BPM)
            k = (w[11:0] != 12'd0) ? W_BPM : W_ILLEGAL;
        else if (w[15:12] == OP_END)
            k = W_END;
        else
            k = W_ILLEGAL;
        return k;
    endfunction

endpackage

// File: rtl/ins_fetch_fifo.sv
// rtl/ins_fetch_fifo.sv - synchronous FIFO holding tagged note entries
module sync_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     valid_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push, do_pop;

    // A push into a full FIFO is accepted only when the head leaves in the same cycle.
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign valid_o = (count_q != '0);
    assign count_o = count_q;

endmodule

// File: rtl/ins_fetch.sv
// rtl/ins_fetch.sv - fetches song words from SRAM, decodes them and queues tempo-tagged notes
module ins_fetch
    import ins_fetch_pkg::*;
#(
    parameter int ADDR_W    = 18,
    parameter int DEPTH     = 4,
    parameter int READ_LAT  = 2,
    parameter int BPM_RESET = 96,
    parameter int LOOP      = 0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              enable_i,
    output logic [ADDR_W-1:0] sram_a_o,
    input  logic [15:0]       sram_d_i,
    output logic              ins_valid_o,
    input  logic              ins_ready_i,
    output logic [15:0]       ins_data_o,
    output logic [11:0]       ins_bpm_o,
    output logic              done_o,
    output logic [7:0]        illegal_cnt_o
);

    localparam int               CNT_W     = $clog2(DEPTH) + 1;
    localparam int               LAT_W     = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
    localparam logic [LAT_W-1:0] WAIT_LAST = LAT_W'((READ_LAT > 1) ? READ_LAT - 2 : 0);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [11:0]      BPM_INIT  = 12'(BPM_RESET);

    state_e             state_q;
    logic [ADDR_W-1:0]  pc_q, sram_a_q;
    logic [11:0]        bpm_q;
    logic [7:0]         ill_q;
    logic [LAT_W-1:0]   wait_q;

    word_e              kind;
    logic               push, pop;
    logic [ENTRY_W-1:0] head;
    logic [CNT_W-1:0]   fifo_cnt, cnt_after;
    logic               room_now, room_next;

    assign kind = decode_word(sram_d_i);
    assign push = (state_q == ST_CAPTURE) && (kind == W_NOTE);
    assign pop  = ins_valid_o && ins_ready_i;

    // Occupancy as it will stand after this edge, so back-to-back issue never overfills.
    always_comb begin
        cnt_after = fifo_cnt;
        if (push) cnt_after = cnt_after + 1'b1;
        if (pop)  cnt_after = cnt_after - 1'b1;
    end

    assign room_now  = (fifo_cnt < FULL_CNT);
    assign room_next = (cnt_after < FULL_CNT);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            sram_a_q <= '0;
            bpm_q    <= BPM_INIT;
            ill_q    <= '0;
            wait_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable_i && room_now) state_q <= ST_ADDR;
                end
                ST_ADDR: begin
                    sram_a_q <= pc_q;
                    wait_q   <= '0;
                    state_q  <= (READ_LAT == 1) ? ST_CAPTURE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (wait_q == WAIT_LAST) state_q <= ST_CAPTURE;
                    else                     wait_q  <= wait_q + 1'b1;
                end
                ST_CAPTURE: begin
                    pc_q <= pc_q + 1'b1;
                    if (kind == W_END) begin
                        if (LOOP != 0) begin
                            pc_q     <= '0;
                            sram_a_q <= '0;
                            bpm_q    <= BPM_INIT;
                            state_q  <= ST_IDLE;
                        end else begin
                            state_q  <= ST_HALT;
                        end
                    end else begin
                        // The address bus follows the PC so a stalled fetcher shows the next word to read.
                        sram_a_q <= pc_q + 1'b1;
                        if (kind == W_BPM) bpm_q <= sram_d_i[11:0];
                        if (kind == W_ILLEGAL && ill_q != 8'hFF) ill_q <= ill_q + 8'd1;
                        state_q <= (enable_i && room_next) ? ST_ADDR : ST_IDLE;
                    end
                end
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .push_i  (push),
        .wdata_i ({sram_d_i, bpm_q}),
        .pop_i   (ins_ready_i),
        .rdata_o (head),
        .valid_o (ins_valid_o),
        .count_o (fifo_cnt)
    );

    assign sram_a_o      = sram_a_q;
    assign ins_data_o    = head[ENTRY_W-1 -: 16];
    assign ins_bpm_o     = head[11:0];
    assign done_o        = (state_q == ST_HALT) && !ins_valid_o;
    assign illegal_cnt_o = ill_q;

endmodule

// File: tb/tb_ins_fetch.sv
// tb/tb_ins_fetch.sv - directed table-driven bench for ins_fetch
module tb_ins_fetch;

    typedef struct packed {
        logic [5:0][15:0] words;
        logic [3:0]       nwords;
        logic [3:0][27:0] exp;
        logic [3:0]       npops;
        logic [7:0]       ill;
        logic [7:0]       amax;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en0, ready0, v0, done0;
    logic        en1, ready1, v1, done1;
    logic [17:0] a0, a1, amax;
    logic [15:0] d0, d1, data0, data1;
    logic [11:0] bpm0, bpm1;
    logic [7:0]  ill0, ill1;
    logic [15:0] mem [512];
    logic [27:0] q0 [$];
    logic [27:0] q1 [$];
    int          checks = 0;
    int          passes = 0;
    vec_t        vecs [6];

    always #10 clk = ~clk;

    ins_fetch #(.LOOP(0)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(en0), .sram_a_o(a0), .sram_d_i(d0),
        .ins_valid_o(v0), .ins_ready_i(ready0), .ins_data_o(data0), .ins_bpm_o(bpm0),
        .done_o(done0), .illegal_cnt_o(ill0)
    );

    ins_fetch #(.LOOP(1)) dut_loop (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(en1), .sram_a_o(a1), .sram_d_i(d1),
        .ins_valid_o(v1), .ins_ready_i(ready1), .ins_data_o(data1), .ins_bpm_o(bpm1),
        .done_o(done1), .illegal_cnt_o(ill1)
    );

    // SRAM model: data for an address is valid one edge after it is presented.
    always @(posedge clk) begin
        d0 <= mem[a0[8:0]];
        d1 <= mem[a1[8:0]];
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (v0 && ready0) q0.push_back({data0, bpm0});
            if (v1 && ready1) q1.push_back({data1, bpm1});
            if (a0 > amax) amax = a0;
        end
    end

    function automatic logic [5:0][15:0] prog(input logic [15:0] w0, w1 = 0, w2 = 0,
                                              w3 = 0, w4 = 0, w5 = 0);
        return {w5, w4, w3, w2, w1, w0};
    endfunction

    function automatic logic [3:0][27:0] pops(input logic [27:0] e0 = 0, e1 = 0,
                                              e2 = 0, e3 = 0);
        return {e3, e2, e1, e0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0; ready0 = 1'b0; ready1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        q0.delete(); q1.delete(); amax = '0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (done0) begin ok = 1'b1; break; end
        end
    endtask

    initial begin
        bit ok;
        vec_t t;

        vecs[0] = '{words: prog(16'h8345, 16'h8212, 16'h0000), nwords: 4'd3,
                    exp: pops({16'h8345, 12'd96}, {16'h8212, 12'd96}), npops: 4'd2, ill: 8'd0, amax: 8'd2};
        vecs[1] = '{words: prog(16'h8001, 16'h1078, 16'h8002, 16'h0000), nwords: 4'd4,
                    exp: pops({16'h8001, 12'd96}, {16'h8002, 12'd120}), npops: 4'd2, ill: 8'd0, amax: 8'd3};
        vecs[2] = '{words: prog(16'h4000, 16'h1000, 16'h8005, 16'h0000), nwords: 4'd4,
                    exp: pops({16'h8005, 12'd96}), npops: 4'd1, ill: 8'd2, amax: 8'd3};
        vecs[3] = '{words: prog(16'h1100, 16'h8010, 16'h1001, 16'h8011, 16'h0000), nwords: 4'd5,
                    exp: pops({16'h8010, 12'h100}, {16'h8011, 12'h001}), npops: 4'd2, ill: 8'd0, amax: 8'd4};
        vecs[4] = '{words: prog(16'h0000), nwords: 4'd1,
                    exp: pops(), npops: 4'd0, ill: 8'd0, amax: 8'd0};
        vecs[5] = '{words: prog(16'hFFFF, 16'h7000, 16'h1FFF, 16'h8000, 16'h0000), nwords: 4'd5,
                    exp: pops({16'hFFFF, 12'd96}, {16'h8000, 12'hFFF}), npops: 4'd2, ill: 8'd1, amax: 8'd4};

        rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0; ready0 = 1'b0; ready1 = 1'b0; amax = '0;
        clear_mem();
        #15;
        chk("reset sram_a", 32'(a0), 32'd0);
        chk("reset valid", 32'(v0), 32'd0);
        chk("reset data", 32'(data0), 32'd0);
        chk("reset bpm", 32'(bpm0), 32'd0);
        chk("reset done", 32'(done0), 32'd0);
        chk("reset illegal", 32'(ill0), 32'd0);

        for (int v = 0; v < 6; v++) begin
            t = vecs[v];
            do_reset();
            clear_mem();
            for (int i = 0; i < int'(t.nwords); i++) mem[i] = t.words[i];
            en0 = 1'b1; ready0 = 1'b1;
            wait_done(ok);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d done", v), 32'(ok), 32'd1);
            chk($sformatf("v%0d pop count", v), 32'(q0.size()), 32'(t.npops));
            for (int i = 0; i < int'(t.npops) && i < q0.size(); i++)
                chk($sformatf("v%0d pop%0d", v, i), 32'(q0[i]), 32'(t.exp[i]));
            chk($sformatf("v%0d illegal", v), 32'(ill0), 32'(t.ill));
            chk($sformatf("v%0d max addr", v), 32'(amax), 32'(t.amax));
        end

        // Backpressure: ten notes with the consumer stalled, then released.
        do_reset();
        clear_mem();
        for (int i = 0; i < 10; i++) mem[i] = 16'h8000 + 16'(i);
        en0 = 1'b1;
        repeat (40) @(negedge clk);
        chk("stall sram_a", 32'(a0), 32'd4);
        chk("stall valid", 32'(v0), 32'd1);
        chk("stall head", 32'(data0), 32'h8000);
        chk("stall no pops", 32'(q0.size()), 32'd0);
        @(posedge clk); #1;
        ready0 = 1'b1;
        wait_done(ok);
        chk("stall done", 32'(ok), 32'd1);
        chk("stall pop count", 32'(q0.size()), 32'd10);
        for (int i = 0; i < 10 && i < q0.size(); i++)
            chk($sformatf("stall pop%0d", i), 32'(q0[i]), 32'({16'h8000 + 16'(i), 12'd96}));

        // Enable dropped during the first read's WAIT cycle.
        do_reset();
        clear_mem();
        mem[0] = 16'h8001; mem[1] = 16'h8002; mem[2] = 16'h8003;
        en0 = 1'b1; ready0 = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        en0 = 1'b0;
        repeat (10) @(negedge clk);
        chk("endrop pops", 32'(q0.size()), 32'd1);
        chk("endrop pc", 32'(a0), 32'd1);
        if (q0.size() > 0) chk("endrop pop0", 32'(q0[0]), 32'({16'h8001, 12'd96}));
        @(posedge clk); #1;
        en0 = 1'b1;
        wait_done(ok);
        chk("endrop done", 32'(ok), 32'd1);
        chk("endrop total", 32'(q0.size()), 32'd3);
        if (q0.size() > 2) chk("endrop pop2", 32'(q0[2]), 32'({16'h8003, 12'd96}));

        // Illegal counter saturation.
        do_reset();
        clear_mem();
        for (int i = 0; i < 300; i++) mem[i] = 16'h2000;
        en0 = 1'b1; ready0 = 1'b1;
        wait_done(ok);
        chk("sat done", 32'(ok), 32'd1);
        chk("sat illegal", 32'(ill0), 32'd255);
        chk("sat pops", 32'(q0.size()), 32'd0);

        // Asynchronous reset pulse during the WAIT cycle of the second read.
        do_reset();
        clear_mem();
        for (int i = 0; i < 3; i++) mem[i] = vecs[0].words[i];
        en0 = 1'b1;
        repeat (5) @(posedge clk);
        #5;
        chk("pre-reset valid", 32'(v0), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset sram_a", 32'(a0), 32'd0);
        chk("midreset valid", 32'(v0), 32'd0);
        chk("midreset data", 32'(data0), 32'd0);
        chk("midreset bpm", 32'(bpm0), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; q0.delete(); amax = '0;
        ready0 = 1'b1;
        repeat (3) @(negedge clk);
        chk("post-reset addr", 32'(a0), 32'd0);
        wait_done(ok);
        chk("post-reset done", 32'(ok), 32'd1);
        chk("post-reset pops", 32'(q0.size()), 32'd2);
        if (q0.size() > 0) chk("post-reset pop0", 32'(q0[0]), 32'({16'h8345, 12'd96}));

        // LOOP=1 instance replays the program forever.
        do_reset();
        clear_mem();
        mem[0] = 16'h1050; mem[1] = 16'h8003;
        en1 = 1'b1; ready1 = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (q1.size() >= 4) begin ok = 1'b1; break; end
        end
        chk("loop pops seen", 32'(ok), 32'd1);
        for (int i = 0; i < 4 && i < q1.size(); i++)
            chk($sformatf("loop pop%0d", i), 32'(q1[i]), 32'({16'h8003, 12'd80}));
        chk("loop done", 32'(done1), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
